// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory controller.
// master drives req_*, slave drives req_ready and rsp_*.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with IDLE/BUSY/RESP access FSM.
// Ports: clk, rst_n (async low), bus (slave side of request/response).
module data_memory_ctrl #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int WORDS = 2 ** (ADDR_BITS - 2);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  logic [31:0] mem [WORDS];

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic uns_q, uns_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic err_q, err_d;

  logic accept;
  logic in_err;
  logic s_we, s_uns, s_err;
  logic [1:0] s_size;
  logic [ADDR_BITS-1:0] s_addr;
  logic [ADDR_BITS-1:0] in_addr;
  logic [31:0] word, b_sh, h_sh, ld;
  logic [31:0] wsh;
  logic [3:0] be;
  logic load_rsp;
  logic unused_hi;

  function automatic logic bad(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    return (sz == 2'b11) ||
           (sz == 2'b01 && lo[0]) ||
           (sz == 2'b10 && lo != 2'b00);
  endfunction

  assign unused_hi = ^bus.req_addr[31:ADDR_BITS];
  assign in_addr = bus.req_addr[ADDR_BITS-1:0];
  assign accept = (state_q == IDLE) && bus.req_valid;
  assign in_err = bad(bus.req_size, in_addr[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = BUSY;
            cnt_d   = WAIT_L;
          end else begin
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d   = we_q;
    uns_d  = uns_q;
    size_d = size_q;
    addr_d = addr_q;
    if (accept) begin
      we_d   = bus.req_we;
      uns_d  = bus.req_unsigned;
      size_d = bus.req_size;
      addr_d = in_addr;
    end
  end

  // With no wait states the response is formed on the accept
  // edge itself, so the live request is used while still IDLE.
  always_comb begin
    s_we   = we_q;
    s_uns  = uns_q;
    s_size = size_q;
    s_addr = addr_q;
    if (state_q == IDLE) begin
      s_we   = bus.req_we;
      s_uns  = bus.req_unsigned;
      s_size = bus.req_size;
      s_addr = in_addr;
    end
  end

  assign s_err = bad(s_size, s_addr[1:0]);
  assign word  = mem[s_addr[ADDR_BITS-1:2]];
  assign b_sh  = word >> {s_addr[1:0], 3'b000};
  assign h_sh  = word >> {s_addr[1], 4'b0000};

  always_comb begin
    ld = 32'd0;
    unique case (s_size)
      2'b00: ld = {{24{~s_uns & b_sh[7]}}, b_sh[7:0]};
      2'b01: ld = {{16{~s_uns & h_sh[15]}}, h_sh[15:0]};
      2'b10: ld = word;
      default: ld = 32'd0;
    endcase
  end

  assign load_rsp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (load_rsp) begin
      err_d   = s_err;
      rdata_d = (s_err || s_we) ? 32'd0 : ld;
    end
  end

  always_comb begin
    be = 4'b0000;
    unique case (bus.req_size)
      2'b00: be = 4'b0001 << in_addr[1:0];
      2'b01: be = 4'b0011 << {in_addr[1], 1'b0};
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!(accept && bus.req_we) || in_err) be = 4'b0000;
  end

  assign wsh = bus.req_wdata << {in_addr[1:0], 3'b000};

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        mem[in_addr[ADDR_BITS-1:2]][8*k +: 8] <= wsh[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (0 and 3 wait states)
// checked each cycle against a byte-array/queue reference model.
module tb_data_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  data_memory_ctrl_if bus0 ();
  data_memory_ctrl_if bus1 ();

  data_memory_ctrl #(
    .ADDR_BITS(12), .WAIT_CYCLES(0)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  data_memory_ctrl #(
    .ADDR_BITS(12), .WAIT_CYCLES(3)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int free_c[2];
  bit chk_en = 0;
  logic [7:0] mm [2][4096];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int id);
    return (id == 0) ? 0 : 3;
  endfunction

  function automatic bit is_err(
    input logic [1:0] sz, input logic [31:0] a
  );
    if (sz == 2'b11) return 1;
    if (sz == 2'b01) return a % 2 != 0;
    if (sz == 2'b10) return a % 4 != 0;
    return 0;
  endfunction

  function automatic logic [31:0] mload(
    input int id, input logic [31:0] a,
    input logic [1:0] sz, input bit uns
  );
    int ea, n;
    logic [31:0] v;
    if (sz == 2'b11) return 32'd0;
    ea = int'(a % 4096);
    n = 1 << sz;
    v = 32'd0;
    for (int k = 0; k < n; k++)
      v = v | (32'(mm[id][(ea + k) % 4096]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1])
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic mstore(
    input int id, input logic [31:0] a,
    input logic [1:0] sz, input logic [31:0] wd
  );
    int ea, n;
    logic [31:0] t;
    ea = int'(a % 4096);
    n = 1 << sz;
    for (int k = 0; k < n; k++) begin
      t = wd >> (8 * k);
      mm[id][(ea + k) % 4096] = t[7:0];
    end
  endtask

  task automatic chk(
    input string nm, input int id,
    input logic [31:0] got, input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h",
               nm, id, cyc, got, exp);
    end
  endtask

  task automatic drive(
    input int id, input bit v, input bit we,
    input logic [1:0] sz, input bit uns,
    input logic [31:0] a, input logic [31:0] wd
  );
    if (id == 0) begin
      bus0.req_valid = v;  bus0.req_we = we;
      bus0.req_size = sz;  bus0.req_unsigned = uns;
      bus0.req_addr = a;   bus0.req_wdata = wd;
    end else begin
      bus1.req_valid = v;  bus1.req_we = we;
      bus1.req_size = sz;  bus1.req_unsigned = uns;
      bus1.req_addr = a;   bus1.req_wdata = wd;
    end
  endtask

  task automatic idle(input int id);
    drive(id, 0, 0, 2'b10, 0, 32'd0, 32'd0);
  endtask

  task automatic wait_cy(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and holds it until the model says it is
  // taken; the model is updated just after the accept edge.
  task automatic issue(
    input int id, input bit we, input logic [1:0] sz,
    input bit uns, input logic [31:0] a,
    input logic [31:0] wd, output logic [31:0] pred
  );
    rsp_t r;
    int n;
    bit e;
    drive(id, 1, we, sz, uns, a, wd);
    while (cyc < free_c[id]) wait_cy(1);
    wait_cy(1);
    n = cyc - 1;
    e = is_err(sz, a);
    r.due = n + wc(id) + 1;
    r.err = e;
    r.rd = (e || we) ? 32'd0 : mload(id, a, sz, uns);
    if (we && !e) mstore(id, a, sz, wd);
    free_c[id] = n + wc(id) + 2;
    if (id == 0) q0.push_back(r);
    else q1.push_back(r);
    pred = r.rd;
  endtask

  task automatic cmp(
    input int id, input logic v, input logic rdy,
    input logic [31:0] rd, input logic e
  );
    rsp_t h;
    bit due;
    due = 0;
    h.due = 0; h.rd = 32'd0; h.err = 1'b0;
    if (id == 0) begin
      if (q0.size() > 0 && q0[0].due <= cyc) begin
        due = (q0[0].due == cyc);
        h = q0.pop_front();
      end
    end else begin
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        due = (q1[0].due == cyc);
        h = q1.pop_front();
      end
    end
    chk("req_ready", id, 32'(rdy), 32'(cyc >= free_c[id]));
    chk("rsp_valid", id, 32'(v), 32'(due));
    if (due) begin
      chk("rsp_rdata", id, rd, h.rd);
      chk("rsp_err", id, 32'(e), 32'(h.err));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, bus0.rsp_valid, bus0.req_ready,
          bus0.rsp_rdata, bus0.rsp_err);
      cmp(1, bus1.rsp_valid, bus1.req_ready,
          bus1.rsp_rdata, bus1.rsp_err);
    end
  end

  task automatic do_reset(input int n);
    idle(0);
    idle(1);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    free_c[0] = 0;
    free_c[1] = 0;
    wait_cy(n);
    rst_n = 1'b1;
  endtask

  logic [31:0] p;

  initial begin
    free_c[0] = 0;
    free_c[1] = 0;
    idle(0);
    idle(1);
    #1;
    rst_n = 1'b0;
    chk_en = 1;
    wait_cy(3);
    rst_n = 1'b1;
    wait_cy(2);

    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, p);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, p);
    chk("pin_lw", 0, p, 32'hDEADBEEF);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, p);
    chk("pin_lb", 0, p, 32'hFFFFFFDE);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, p);
    chk("pin_lbu", 0, p, 32'h000000DE);
    issue(0, 0, 2'b01, 0, 32'h10, 32'h0, p);
    chk("pin_lh", 0, p, 32'hFFFFBEEF);
    issue(0, 0, 2'b01, 1, 32'h12, 32'h0, p);
    chk("pin_lhu", 0, p, 32'h0000DEAD);
    idle(0);
    wait_cy(2);
    issue(0, 1, 2'b00, 0, 32'h11, 32'h55, p);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, p);
    chk("pin_sb", 0, p, 32'hDEAD55EF);
    issue(0, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, p);
    issue(0, 1, 2'b01, 0, 32'h21, 32'hBBBB, p);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, p);
    chk("pin_err_nowr", 0, p, 32'hCAFEF00D);
    issue(0, 0, 2'b11, 0, 32'h20, 32'h0, p);
    issue(0, 0, 2'b10, 0, 32'h22, 32'h0, p);
    issue(0, 1, 2'b10, 0, 32'h1004, 32'h12345678, p);
    issue(0, 0, 2'b10, 0, 32'h4, 32'h0, p);
    chk("pin_wrap", 0, p, 32'h12345678);
    issue(0, 0, 2'b01, 0, 32'hFFFF_F006, 32'h0, p);
    chk("pin_wrap_lh", 0, p, 32'h00001234);
    idle(0);
    wait_cy(3);

    issue(1, 1, 2'b10, 0, 32'h80, 32'h11223344, p);
    issue(1, 0, 2'b10, 0, 32'h80, 32'h0, p);
    chk("pin_w3_lw", 1, p, 32'h11223344);
    issue(1, 0, 2'b00, 1, 32'h81, 32'h0, p);
    chk("pin_w3_lbu", 1, p, 32'h00000033);
    issue(1, 1, 2'b01, 0, 32'h83, 32'h0, p);
    issue(1, 1, 2'b10, 0, 32'h40, 32'h0BADF00D, p);
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, p);
    idle(1);
    wait_cy(1);
    do_reset(2);
    wait_cy(2);
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, p);
    chk("pin_post_rst", 1, p, 32'h0BADF00D);
    issue(1, 0, 2'b01, 0, 32'h82, 32'h0, p);
    chk("pin_w3_lh", 1, p, 32'h00001122);
    idle(1);

    wait_cy(10);
    chk("drain", 0, 32'(q0.size()), 32'd0);
    chk("drain", 1, 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
